// File: rtl/card_dealer_pkg.sv
// -----------------------------------------------------------------------------
// dealer_pkg
// Shared types and constants for the card dealer and related game blocks.
//   CARD_W    : width of one card value (1..13)
//   DECK_SIZE : default number of cards per deck
//   PTR_W     : width of deck pointers / counters
//   LFSR_TAPS : Galois feedback taps for the 16-bit LFSR
//   state_t   : dealer FSM states
//   mask_for  : smallest all-ones value that is >= i (shuffle index mask)
// -----------------------------------------------------------------------------
package dealer_pkg;

    localparam int          CARD_W    = 4;
    localparam int          DECK_SIZE = 52;
    localparam int          PTR_W     = 6;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        SHUFFLE = 2'd1,
        READY   = 2'd2
    } state_t;

    // Smearing the bits of i downwards yields 2^k-1 with 2^k-1 >= i.
    function automatic logic [PTR_W-1:0] mask_for(input logic [PTR_W-1:0] i);
        logic [PTR_W-1:0] m;
        m = i;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// -----------------------------------------------------------------------------
// card_dealer_if
// Request/response bundle between the game controller (master) and the
// card dealer (slave).
//   pip        : deal request, one-cycle pulse          (master -> slave)
//   reshuffle  : restart with a full deck, pulse        (master -> slave)
//   number     : last dealt card value, 1..13           (slave -> master)
//   ready      : deck shuffled and able to deal         (slave -> master)
//   cards_left : undealt cards, 0..52                   (slave -> master)
// -----------------------------------------------------------------------------
interface card_dealer_if;
    import dealer_pkg::*;

    logic              pip;
    logic              reshuffle;
    logic [CARD_W-1:0] number;
    logic              ready;
    logic [PTR_W-1:0]  cards_left;

    modport master (
        output pip, reshuffle,
        input  number, ready, cards_left
    );

    modport slave (
        input  pip, reshuffle,
        output number, ready, cards_left
    );

endinterface

// File: rtl/card_dealer_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Galois LFSR (right-shifting). With maximal-length taps
// and a nonzero seed it never reaches the all-zero state.
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads SEED
//   q     : current LFSR state
// Parameters: SEED (must be nonzero), TAPS (feedback polynomial).
// -----------------------------------------------------------------------------
module lfsr16
    import dealer_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = LFSR_TAPS
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q >> 1;
        if (q_q[0]) begin
            q_d = (q_q >> 1) ^ TAPS;
        end
    end

    // NOTE: state registers use non-blocking (<=) assignments so every
    // flop samples the pre-edge values of all other flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/card_dealer.sv
// -----------------------------------------------------------------------------
// card_dealer
// 52-card deck (SUITS copies of each value 1..13). INIT fills the deck in
// order, SHUFFLE runs an LFSR-driven Fisher-Yates pass, READY deals one card
// per pip without replacement. number is registered, so it is valid the
// cycle after pip. Exhausting the deck triggers an automatic reshuffle; a
// pip arriving while not READY is held (depth 1) and served from the new deck.
//   clk        : controller's slow logic clock
//   rst_n      : asynchronous active-low reset
//   dif        : card_dealer_if.slave (pip, reshuffle, number, ready,
//                cards_left)
// Parameters: DECK_SIZE (= SUITS*13), SUITS, LFSR_SEED (nonzero).
// Build option: define DEALER_FIXED_DECK_EN to skip SHUFFLE, giving the
// deterministic deal order 1,2,...,13,1,2,... for bring-up.
// -----------------------------------------------------------------------------
module card_dealer #(
    parameter int          DECK_SIZE = dealer_pkg::DECK_SIZE,
    parameter int          SUITS     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    card_dealer_if.slave     dif
);
    import dealer_pkg::*;

    localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(SUITS * 13 - 1);
    localparam logic [PTR_W-1:0]  FULL_DECK = PTR_W'(DECK_SIZE);
    localparam logic [CARD_W-1:0] MAX_VAL   = CARD_W'(13);

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  idx_q, idx_d;      // k while filling, i while shuffling
    logic [CARD_W-1:0] fill_q, fill_d;    // (k mod 13)+1 without a divider
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              pending_q, pending_d;
    logic [CARD_W-1:0] number_q, number_d;
    logic              ready_q, ready_d;
    logic [PTR_W-1:0]  cards_left_q, cards_left_d;

    logic [CARD_W-1:0] deck_q [DECK_SIZE];

    logic [15:0]       lfsr;
    logic              lfsr_unused;       // only the low bits feed the shuffle
    logic [PTR_W-1:0]  cand;
    logic              init_wr;
    logic              swap_en;
    logic              deal;

    lfsr16 #(
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:PTR_W];

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fill_d       = fill_q;
        ptr_d        = ptr_q;
        pending_d    = pending_q;
        number_d     = number_q;
        ready_d      = ready_q;
        cards_left_d = cards_left_q;
        init_wr      = 1'b0;
        swap_en      = 1'b0;
        deal         = 1'b0;
        cand         = lfsr[PTR_W-1:0] & mask_for(idx_q);

        case (state_q)
            INIT: begin
                init_wr = 1'b1;
                if (idx_q == LAST_IDX) begin
`ifdef DEALER_FIXED_DECK_EN
                    state_d      = READY;
                    ptr_d        = '0;
                    cards_left_d = FULL_DECK;
                    ready_d      = 1'b1;
`else
                    // idx already holds the top index, which is where i starts.
                    state_d = SHUFFLE;
`endif
                end else begin
                    idx_d  = idx_q + PTR_W'(1);
                    fill_d = (fill_q == MAX_VAL) ? CARD_W'(1) : fill_q + CARD_W'(1);
                end
            end

            SHUFFLE: begin
                // A candidate above i is rejected rather than folded, keeping
                // the pick uniform over 0..i.
                if (cand <= idx_q) begin
                    swap_en = 1'b1;
                    idx_d   = idx_q - PTR_W'(1);
                    if (idx_q == PTR_W'(1)) begin
                        state_d      = READY;
                        ptr_d        = '0;
                        cards_left_d = FULL_DECK;
                        ready_d      = 1'b1;
                    end
                end
            end

            READY: begin
                // pending can only be set outside READY, so it is only seen
                // here on the first READY cycle.
                deal = dif.pip || pending_q;
                if (deal) begin
                    number_d     = deck_q[ptr_q];
                    ptr_d        = ptr_q + PTR_W'(1);
                    cards_left_d = cards_left_q - PTR_W'(1);
                    pending_d    = 1'b0;
                    if (ptr_q == LAST_IDX) begin
                        state_d      = INIT;
                        idx_d        = '0;
                        fill_d       = CARD_W'(1);
                        ptr_d        = '0;
                        ready_d      = 1'b0;
                        cards_left_d = '0;
                    end
                end
            end

            default: begin
                state_d = INIT;
            end
        endcase

        if ((state_q != READY) && dif.pip) begin
            pending_d = 1'b1;
        end

        // Reshuffle wins over everything except the deal itself, which has
        // already updated number above; pending survives on purpose.
        if (dif.reshuffle) begin
            state_d      = INIT;
            idx_d        = '0;
            fill_d       = CARD_W'(1);
            ptr_d        = '0;
            ready_d      = 1'b0;
            cards_left_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            idx_q        <= '0;
            fill_q       <= CARD_W'(1);
            ptr_q        <= '0;
            pending_q    <= 1'b0;
            number_q     <= '0;
            ready_q      <= 1'b0;
            cards_left_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fill_q       <= fill_d;
            ptr_q        <= ptr_d;
            pending_q    <= pending_d;
            number_q     <= number_d;
            ready_q      <= ready_d;
            cards_left_q <= cards_left_d;
        end
    end

    // NOTE: the deck storage has no reset; INIT rewrites every entry before
    // anything reads it, so a reset network on it would buy nothing.
    always_ff @(posedge clk) begin
        if (init_wr) begin
            deck_q[idx_q] <= fill_q;
        end else if (swap_en) begin
            // Both reads see pre-edge contents, so this is a true swap
            // (and a harmless self-write when cand == i).
            deck_q[idx_q] <= deck_q[cand];
            deck_q[cand]  <= deck_q[idx_q];
        end
    end

    assign dif.number     = number_q;
    assign dif.ready      = ready_q;
    assign dif.cards_left = cards_left_q;

endmodule
